seq_pattern_gen: RTL and testbench



---
 rtl/seq_pattern_gen_if.sv | 26 ++
 rtl/seq_pattern_gen.sv | 111 +++++++++++
 tb/tb_seq_pattern_gen.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_gen_if.sv
// Load handshake and serial output bundle for seq_pattern_gen.
// Handshake: a load is accepted on a rising edge where load_valid && load_ready; the requester holds load_valid and its payload until then.
interface seq_pattern_gen_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, pattern, repeat_cnt, abort,
    input  load_ready, x, x_valid, busy, done
  );

  modport slave (
    input  load_valid, pattern, repeat_cnt, abort,
    output load_ready, x, x_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first for repeat_cnt+1
// back-to-back passes, flagging valid bits and pulsing done once after the final bit.
module seq_pattern_gen #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  seq_pattern_gen_if.slave bus
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pat_q,   pat_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] pass_q,  pass_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             done_q, done_d;
  logic             accept;

  assign bus.load_ready = (state_q == IDLE) && !bus.abort;
  assign accept         = bus.load_valid && bus.load_ready;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.x          = x_q;
  assign bus.x_valid    = x_valid_q;
  assign bus.done       = done_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    bit_cnt_d = bit_cnt_q;
    pass_d    = pass_q;
    x_d       = x_q;
    x_valid_d = x_valid_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        if (accept) begin
          // The MSB goes straight to x so the first bit appears the cycle after acceptance.
          state_d   = SHIFT;
          shreg_d   = bus.pattern;
          pat_d     = bus.pattern;
          pass_d    = bus.repeat_cnt;
          bit_cnt_d = LAST_IDX;
          x_d       = bus.pattern[WIDTH-1];
          x_valid_d = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d   = IDLE;
          shreg_d   = '0;
          pat_d     = '0;
          bit_cnt_d = '0;
          pass_d    = '0;
          x_d       = 1'b0;
          x_valid_d = 1'b0;
        end else if (bit_cnt_q != '0) begin
          shreg_d   = shreg_q << 1;
          x_d       = shreg_q[WIDTH-2];
          bit_cnt_d = bit_cnt_q - 1'b1;
        end else if (pass_q != '0) begin
          shreg_d   = pat_q;
          pass_d    = pass_q - 1'b1;
          bit_cnt_d = LAST_IDX;
          x_d       = pat_q[WIDTH-1];
        end else begin
          state_d   = IDLE;
          x_d       = 1'b0;
          x_valid_d = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      pat_q     <= '0;
      bit_cnt_q <= '0;
      pass_q    <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      pat_q     <= pat_d;
      bit_cnt_q <= bit_cnt_d;
      pass_q    <= pass_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Randomized and directed bench for seq_pattern_gen; expected serial stream built from the load
// requests and checked by an independent monitor.
module tb_seq_pattern_gen;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  seq_pattern_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  seq_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Each token is {last_bit_of_transmission, bit}.
  logic [1:0] exp_q[$];
  logic       done_due;
  int         total;
  int         bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stream is the pattern MSB-first, repeated rep+1 times.
  task automatic push_expected(input logic [WIDTH-1:0] pat, input int rep);
    int n;
    n = WIDTH * (rep + 1);
    for (int i = 0; i < n; i++) begin
      logic b;
      b = pat[WIDTH - 1 - (i % WIDTH)];
      exp_q.push_back({(i == n - 1), b});
    end
  endtask

  task automatic flush_expected();
    exp_q.delete();
    done_due = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] pat, input int rep, input bit hold);
    bit accepted;
    int budget;
    accepted = 0;
    budget = 0;
    bus.load_valid = 1'b1;
    bus.pattern    = pat;
    bus.repeat_cnt = CNT_W'(rep);
    while (!accepted && budget < 200) begin
      @(negedge clk);
      accepted = bus.load_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!accepted) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got not-accepted expected accepted at %0t", $time);
    end else begin
      push_expected(pat, rep);
    end
    if (!hold) begin
      bus.load_valid = 1'b0;
      bus.pattern    = WIDTH'($urandom);
      bus.repeat_cnt = CNT_W'($urandom);
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || bus.busy || done_due) && budget < 300) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 300) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy expected idle at %0t", $time);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops one token per valid bit and checks busy/done timing every cycle.
  initial begin
    logic [1:0] tok;
    logic       last;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_due = 1'b0;
      end else begin
        last = 1'b0;
        check("busy", bus.busy, exp_q.size() != 0);
        if (bus.x_valid) begin
          if (exp_q.size() == 0) begin
            check("extra_bit", 1, 0);
          end else begin
            tok = exp_q.pop_front();
            check("x", bus.x, tok[0]);
            last = tok[1];
          end
        end else if (exp_q.size() != 0) begin
          check("gap", bus.x_valid, 1);
        end
        check("done", bus.done, done_due);
        if (bus.done) check("ready_in_done", bus.load_ready, 1);
        done_due = last;
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    done_due = 1'b0;
    rst_n = 1'b0;
    bus.load_valid = 1'b0;
    bus.pattern    = '0;
    bus.repeat_cnt = '0;
    bus.abort      = 1'b0;
    idle_cycles(3);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_x", bus.x, 0);
    check("rst_x_valid", bus.x_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.load_ready, 1);

    // Reset mid-transmission clears outputs asynchronously.
    send(4'b1010, 1, 0);
    idle_cycles(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_x", bus.x, 0);
    check("async_rst_x_valid", bus.x_valid, 0);
    check("async_rst_busy", bus.busy, 0);
    flush_expected();
    idle_cycles(2);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pass and three passes of 1010.
    send(4'b1010, 0, 0);
    wait_idle();
    send(4'b1010, 2, 0);
    wait_idle();

    // load_valid held through busy: second load taken in the done cycle.
    send(4'b1101, 0, 1);
    send(4'b1101, 0, 0);
    wait_idle();
    idle_cycles(1);

    // Abort on bit 3 of pass 2 of 1001 x4; done must never pulse.
    send(4'b1001, 3, 0);
    idle_cycles(5);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    flush_expected();
    check("abort_busy", bus.busy, 0);
    check("abort_x_valid", bus.x_valid, 0);
    idle_cycles(2);

    // Load presented with abort in IDLE is refused.
    bus.abort = 1'b1;
    bus.load_valid = 1'b1;
    bus.pattern = 4'b1111;
    @(negedge clk);
    check("abort_idle_ready", bus.load_ready, 0);
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    bus.abort = 1'b0;
    check("abort_idle_busy", bus.busy, 0);
    idle_cycles(2);

    // Maximum repeat count: 64 bits then one done.
    send(4'b0110, 15, 0);
    wait_idle();

    // Random transmissions, some back-to-back, some with idle gaps.
    for (int i = 0; i < 25; i++) begin
      logic [WIDTH-1:0] p;
      int r;
      p = WIDTH'($urandom);
      r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      send(p, r, 0);
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        idle_cycles($urandom_range(0, 3));
      end
    end
    wait_idle();

    // Random abort at a random point of a transmission.
    for (int i = 0; i < 4; i++) begin
      send(WIDTH'($urandom), $urandom_range(1, 3), 0);
      idle_cycles($urandom_range(0, 5));
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      flush_expected();
      check("rand_abort_busy", bus.busy, 0);
      idle_cycles(1);
    end
    idle_cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
